mdu_hilo: RTL and testbench
===========================

// Module: mdu_hilo
// PURPOSE
//  Parametrised multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core.
//  Sits in the execute stage beside the ALU; accepts MULT/DIV/MTHI/MTLO (and optional MADD/MSUB),
//  runs multi-cycle ops, stalls the pipeline through a handshake and commits results to HI/LO.
// PARAMETERS
//  WIDTH       32  operand width and width of each of HI and LO
//  MUL_CYCLES  1   multiply latency in cycles, legal 1..4
//  ACC_EN      0   1 enables MADD/MADDU/MSUB/MSUBU; 0 treats those as NOP
// PORTS
//  clk         in   1        core clock; all state updates on the rising edge
//  rst         in   1        synchronous, active-high reset
//  start_i     in   1        EX-stage instruction is an MDU op (level, held while stalled)
//  op_i        in   4        mdu_pkg::mdu_op_t: NOP,MULT,MULTU,DIV,DIVU,MTHI,MTLO,MADD,MADDU,MSUB,MSUBU
//  a_i         in   WIDTH    rs operand (dividend / multiplicand / MTHI-MTLO source)
//  b_i         in   WIDTH    rt operand (divisor / multiplier)
//  flush_i     in   1        flushE: abort any in-flight op, HI/LO unchanged
//  stall_ext_i in   1        EX held by another hazard source this cycle
//  stall_o     out  1        hold F/D/E until result committed
//  done_o      out  1        registered 1-cycle pulse: HI/LO hold the new result
//  hi_o        out  WIDTH    HI register
//  lo_o        out  WIDTH    LO register
// BEHAVIOUR
//  Reset: hi_o=lo_o=0, stall_o=0, done_o=0, state IDLE, counter 0; reset mid-op aborts with no commit.
//  States: IDLE, MUL, DIV, FIX. Accept = start_i & state==IDLE & !done_q & !flush_i.
//  stall_o = busy | (start_i & op is MULT/DIV/MADD/MSUB class & !done_q); combinational.
//  MTHI/MTLO: no stall; write a_i to HI/LO at the accept edge. NOP: ignored.
//  MULT(U): 2*WIDTH product, signed/unsigned; HI=upper, LO=lower half. Written at the edge ending
//   cycle MUL_CYCLES-1 after accept cycle 0; stall_o high cycles 0..MUL_CYCLES-1; done in cycle MUL_CYCLES.
//  MADD/MSUB (ACC_EN): {HI,LO} +/- product, modulo 2^(2*WIDTH); same latency as MULT.
//  DIV(U): cycle 0 latches |a|,|b| and signs; DIV state runs WIDTH restoring iterations, one per cycle;
//   FIX applies signs (quotient neg if signs differ, remainder takes dividend sign) and writes
//   LO=quotient, HI=remainder. stall_o high WIDTH+2 cycles; done_o in cycle WIDTH+2.
//  Divide by zero (both signs): LO=all ones, HI=a_i unchanged; same latency, no exception.
//  DIV most-negative / -1: LO=most-negative (wrap), HI=0.
//  done_q set at commit edge; held while stall_ext_i=1; cleared on first cycle with stall_ext_i=0
//   or flush_i; while set, start_i is ignored (same instruction still in EX, no restart).
//  flush_i: priority over start_i; busy state -> IDLE next edge, partial result discarded,
//   HI/LO keep old values; flush in done cycle clears done_q only (commit already done).
//  MTHI/MTLO asserted while busy cannot occur (pipeline stalled); if it does, ignored (assert).
// STRUCTURE
//  mdu_pkg: mdu_op_t enum, mdu_state_t enum, is_muldiv()/is_signed() helper functions.
//  Sub-module mdu_divider: iterative radix-2 restoring divider core (load, step, quotient/remainder).
//  Multiplier: behavioural '*' followed by MUL_CYCLES-1 pipeline registers in this module.
// TESTING
//  MULT a=-3 b=7, MUL_CYCLES=1 -> stall 1 cycle, done next; HI=FFFFFFFF LO=FFFFFFEB.
//  DIVU a=100 b=7 -> stall exactly 34 cycles; LO=14 HI=2; DIV a=-7 b=2 -> LO=-3 HI=-1.
//  DIV a=80000000 b=FFFFFFFF -> LO=80000000 HI=0; DIVU b=0 a=5 -> LO=FFFFFFFF HI=5.
//  flush_i in cycle 10 of DIV after MTHI 0x1234 -> IDLE next cycle, HI=1234, no done_o.
//  Done cycle with stall_ext_i=1 for 3 cycles, start_i held -> no restart, single commit.
//  ACC_EN=1: HI:LO=0:10, MADDU 3*4 -> LO=22; MSUB 2*(-1)... LO=24; reset mid-MUL -> all 0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types and opcode helpers for the multiply/divide unit and its HI/LO registers.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } mdu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } mdu_state_t;

  function automatic logic is_mul(mdu_op_t op);
    return op inside {OP_MULT, OP_MULTU};
  endfunction

  function automatic logic is_div(mdu_op_t op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction

  function automatic logic is_acc(mdu_op_t op);
    return op inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
  endfunction

  function automatic logic is_sub(mdu_op_t op);
    return op inside {OP_MSUB, OP_MSUBU};
  endfunction

  // Multi-cycle ops that stall the pipeline; accumulate ops only count when enabled.
  function automatic logic is_muldiv(mdu_op_t op, logic acc_en);
    return is_mul(op) || is_div(op) || (acc_en && is_acc(op));
  endfunction

  function automatic logic is_signed(mdu_op_t op);
    return op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
  endfunction

endpackage

// File: rtl/mdu_hilo_if.sv
// EX-stage to MDU connection: operation request, pipeline hazard controls and HI/LO results.
interface mdu_hilo_if #(
  parameter int WIDTH = 32
);
  import mdu_pkg::*;

  logic             start_i;
  mdu_op_t          op_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             flush_i;
  logic             stall_ext_i;
  logic             stall_o;
  logic             done_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start_i, op_i, a_i, b_i, flush_i, stall_ext_i,
    input  stall_o, done_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i, flush_i, stall_ext_i,
    output stall_o, done_o, hi_o, lo_o
  );
endinterface

// File: rtl/mdu_divider.sv
// Iterative radix-2 restoring divider on unsigned magnitudes: one quotient bit per step.
module mdu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    rem_d   = rem_q;
    quo_d   = quo_q;
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
    if (load_i) begin
      rem_d = '0;
      quo_d = dividend_i;
    end else if (step_i) begin
      // diff[WIDTH] set means the trial subtraction went negative: restore.
      if (!diff[WIDTH]) begin
        rem_d = diff[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = shifted[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  // NOTE: pure datapath, deliberately not reset -- every divide loads it before the first step.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so all registers see pre-edge values.
    rem_q <= rem_d;
    quo_q <= quo_d;
    if (load_i) dvs_q <= divisor_i;
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/mdu_hilo.sv
// Multiply/divide unit with architectural HI/LO for the EX stage; stalls the pipe until commit.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 1,
  parameter int ACC_EN     = 0
) (
  input logic       clk,
  input logic       rst,
  mdu_hilo_if.slave bus
);

  localparam int   PIPE  = (MUL_CYCLES > 1) ? MUL_CYCLES - 1 : 1;
  localparam int   CNT_W = $clog2(WIDTH + 1);
  localparam logic ACC   = (ACC_EN != 0);

  mdu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  mdu_op_t          op_q;
  logic [WIDTH-1:0] a_q;
  logic             neg_quo_q, neg_rem_q, div0_q;
  logic [2*WIDTH-1:0] pipe_q [PIPE];

  mdu_op_t          op;
  logic [WIDTH-1:0] a, b;
  logic             sgn, long_op, mul_class;
  logic             busy, accept, div_load, div_step, mul_commit, div_commit;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod_now, cprod, acc_val, mul_res;
  mdu_op_t          cop;
  logic [WIDTH-1:0] a_abs, b_abs, quotient, remainder;

  assign op = bus.op_i;
  assign a  = bus.a_i;
  assign b  = bus.b_i;

  always_comb begin
    sgn       = is_signed(op);
    long_op   = is_muldiv(op, ACC);
    mul_class = long_op & ~is_div(op);
    a_ext     = {{WIDTH{sgn & a[WIDTH-1]}}, a};
    b_ext     = {{WIDTH{sgn & b[WIDTH-1]}}, b};
    prod_now  = a_ext * b_ext;
    a_abs     = (sgn && a[WIDTH-1]) ? -a : a;
    b_abs     = (sgn && b[WIDTH-1]) ? -b : b;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && long_op) begin
          if (is_div(op)) begin
            state_d = ST_DIV;
            cnt_d   = '0;
          end else if (MUL_CYCLES > 1) begin
            state_d = ST_MUL;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      ST_MUL: begin
        if (cnt_q == CNT_W'(MUL_CYCLES - 1)) state_d = ST_IDLE;
        else                                 cnt_d   = cnt_q + 1'b1;
      end
      ST_DIV: begin
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FIX;
        else                            cnt_d   = cnt_q + 1'b1;
      end
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (bus.flush_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  // done_q blocks re-acceptance: the committed instruction may still sit in EX.
  always_comb begin
    busy        = (state_q != ST_IDLE);
    accept      = bus.start_i & ~busy & ~done_q & ~bus.flush_i;
    bus.stall_o = busy | (bus.start_i & long_op & ~done_q);
    div_load    = accept & is_div(op);
    div_step    = (state_q == ST_DIV);
    div_commit  = (state_q == ST_FIX) & ~bus.flush_i;
    if (MUL_CYCLES == 1) mul_commit = accept & mul_class;
    else mul_commit = (state_q == ST_MUL) & (cnt_q == CNT_W'(MUL_CYCLES - 1)) & ~bus.flush_i;
  end

  mdu_divider #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .load_i     (div_load),
    .step_i     (div_step),
    .dividend_i (a_abs),
    .divisor_i  (b_abs),
    .quotient_o (quotient),
    .remainder_o(remainder)
  );

  always_ff @(posedge clk) begin
    if (accept && long_op) begin
      op_q      <= op;
      a_q       <= a;
      neg_quo_q <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_rem_q <= sgn & a[WIDTH-1];
      div0_q    <= (b == '0);
      pipe_q[0] <= prod_now;
    end
    for (int k = 1; k < PIPE; k++) pipe_q[k] <= pipe_q[k-1];
  end

  always_comb begin
    cop     = (MUL_CYCLES == 1) ? op : op_q;
    cprod   = (MUL_CYCLES == 1) ? prod_now : pipe_q[PIPE-1];
    acc_val = {hi_q, lo_q};
    if (ACC && is_acc(cop)) mul_res = is_sub(cop) ? acc_val - cprod : acc_val + cprod;
    else                    mul_res = cprod;

    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = done_q & bus.stall_ext_i & ~bus.flush_i;
    if (accept && op == OP_MTHI) hi_d = a;
    if (accept && op == OP_MTLO) lo_d = a;
    if (mul_commit) begin
      {hi_d, lo_d} = mul_res;
      done_d       = 1'b1;
    end
    if (div_commit) begin
      if (div0_q) begin
        lo_d = '1;
        hi_d = a_q;
      end else begin
        lo_d = neg_quo_q ? -quotient : quotient;
        hi_d = neg_rem_q ? -remainder : remainder;
      end
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
    end
  end

  assign bus.done_o = done_q;
  assign bus.hi_o   = hi_q;
  assign bus.lo_o   = lo_q;

  // A stalled pipeline cannot present MTHI/MTLO while busy; such a request is ignored.
  a_no_mt_busy: assert property (@(posedge clk) disable iff (rst)
    !(bus.start_i && busy && (bus.op_i == OP_MTHI || bus.op_i == OP_MTLO)));

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed bench for mdu_hilo (WIDTH=32, MUL_CYCLES=1, ACC_EN=1) with hand-computed results.
module tb_mdu_hilo;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  mdu_hilo_if #(.WIDTH(32)) bus ();

  mdu_hilo #(.WIDTH(32), .MUL_CYCLES(1), .ACC_EN(1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Issue a multi-cycle op and hold it until stall_o drops, then check the done cycle.
  task automatic run_long(input string tag, input mdu_op_t op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_stall,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    bit ended;
    @(posedge clk); #1;
    bus.op_i = op; bus.a_i = a; bus.b_i = b; bus.start_i = 1'b1;
    n = 0;
    ended = 1'b0;
    for (int i = 0; i < 100 && !ended; i++) begin
      @(negedge clk);
      if (bus.stall_o) begin
        n++;
        @(posedge clk); #1;
      end else begin
        ended = 1'b1;
      end
    end
    check({tag, "_stall"}, n, exp_stall);
    check({tag, "_done"}, 32'(bus.done_o), 32'd1);
    check({tag, "_hi"}, bus.hi_o, exp_hi);
    check({tag, "_lo"}, bus.lo_o, exp_lo);
    @(posedge clk); #1;
    bus.start_i = 1'b0; bus.op_i = OP_NOP;
    @(negedge clk);
    check({tag, "_done_clr"}, 32'(bus.done_o), 32'd0);
  endtask

  task automatic move_to(input mdu_op_t op, input logic [31:0] a);
    @(posedge clk); #1;
    bus.op_i = op; bus.a_i = a; bus.start_i = 1'b1;
    @(negedge clk);
    check("mt_nostall", 32'(bus.stall_o), 32'd0);
    @(posedge clk); #1;
    bus.start_i = 1'b0; bus.op_i = OP_NOP;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ndone;
    rst = 1'b1;
    bus.start_i = 1'b0; bus.op_i = OP_NOP; bus.a_i = '0; bus.b_i = '0;
    bus.flush_i = 1'b0; bus.stall_ext_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_hi", bus.hi_o, 32'h0);
    check("rst_lo", bus.lo_o, 32'h0);
    check("rst_stall", 32'(bus.stall_o), 32'd0);
    check("rst_done", 32'(bus.done_o), 32'd0);

    run_long("mult_neg",  OP_MULT,  32'hFFFFFFFD, 32'd7,        1, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_long("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'd2,        1, 32'h00000001, 32'hFFFFFFFE);
    run_long("divu",      OP_DIVU,  32'd100,      32'd7,       34, 32'd2,        32'd14);
    run_long("div_neg",   OP_DIV,   32'hFFFFFFF9, 32'd2,       34, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_long("div_ovf",   OP_DIV,   32'h80000000, 32'hFFFFFFFF, 34, 32'h0,       32'h80000000);
    run_long("divu_z",    OP_DIVU,  32'd5,        32'd0,       34, 32'd5,        32'hFFFFFFFF);
    run_long("div_z",     OP_DIV,   32'hFFFFFFFB, 32'd0,       34, 32'hFFFFFFFB, 32'hFFFFFFFF);
    run_long("div_negb",  OP_DIV,   32'd7,        32'hFFFFFFFE, 34, 32'd1,       32'hFFFFFFFD);

    // Flush in cycle 10 of a divide: no commit, HI/LO keep MTHI value and previous LO.
    move_to(OP_MTHI, 32'h1234);
    check("mthi", bus.hi_o, 32'h1234);
    @(posedge clk); #1;
    bus.op_i = OP_DIVU; bus.a_i = 32'd100; bus.b_i = 32'd7; bus.start_i = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    bus.flush_i = 1'b1;
    @(negedge clk);
    check("flush_busy", 32'(bus.stall_o), 32'd1);
    @(posedge clk); #1;
    bus.flush_i = 1'b0; bus.start_i = 1'b0; bus.op_i = OP_NOP;
    @(negedge clk);
    check("flush_idle", 32'(bus.stall_o), 32'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done_o) ndone++;
    end
    check("flush_nodone", ndone, 0);
    check("flush_hi", bus.hi_o, 32'h1234);
    check("flush_lo", bus.lo_o, 32'hFFFFFFFD);

    // Accumulate ops, including a borrow through HI.
    move_to(OP_MTHI, 32'h0);
    move_to(OP_MTLO, 32'd10);
    check("mtlo", bus.lo_o, 32'd10);
    run_long("maddu", OP_MADDU, 32'd3, 32'd4,        1, 32'h0, 32'd22);
    run_long("msub",  OP_MSUB,  32'd2, 32'hFFFFFFFF, 1, 32'h0, 32'd24);
    run_long("msubu", OP_MSUBU, 32'd1, 32'h19,       1, 32'hFFFFFFFF, 32'hFFFFFFFF);

    // Done cycle held by an external stall for 3 cycles: a restart would add 5 twice.
    @(posedge clk); #1;
    bus.op_i = OP_MADDU; bus.a_i = 32'd1; bus.b_i = 32'd5; bus.start_i = 1'b1;
    @(negedge clk);
    check("ext_stall0", 32'(bus.stall_o), 32'd1);
    @(posedge clk); #1;
    bus.stall_ext_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ext_done_held", 32'(bus.done_o), 32'd1);
      check("ext_nostall", 32'(bus.stall_o), 32'd0);
      @(posedge clk); #1;
    end
    bus.stall_ext_i = 1'b0;
    @(negedge clk);
    check("ext_done_last", 32'(bus.done_o), 32'd1);
    @(posedge clk); #1;
    bus.start_i = 1'b0; bus.op_i = OP_NOP;
    @(negedge clk);
    check("ext_done_clr", 32'(bus.done_o), 32'd0);
    check("ext_hi", bus.hi_o, 32'h0);
    check("ext_lo", bus.lo_o, 32'd4);

    // Reset asserted in the MULT accept cycle: nothing commits, everything clears.
    move_to(OP_MTHI, 32'hABCD);
    @(posedge clk); #1;
    bus.op_i = OP_MULT; bus.a_i = 32'd3; bus.b_i = 32'd3; bus.start_i = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.start_i = 1'b0; bus.op_i = OP_NOP;
    @(negedge clk);
    check("rstmul_hi", bus.hi_o, 32'h0);
    check("rstmul_lo", bus.lo_o, 32'h0);
    check("rstmul_done", 32'(bus.done_o), 32'd0);
    check("rstmul_stall", 32'(bus.stall_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
